shift_arbiter: RTL and testbench
================================

// Module: shift_arbiter
// PURPOSE
//  Shares the memory-mapped shift peripheral between two requesters (port 0, port 1).
//  Round-robin arbitration; runs the full peripheral bus sequence per job: write INFO,
//  write ORIGINAL, kick, wait, read RESULT. Returns the result with a one-cycle done pulse.
//  Sits between the requesters and the peripheral's reg_sel/data_in/cs/we/data_out bus.
// PARAMETERS
//  WAIT_CYC  18  cycles in WAIT after KICK before RESULT is read (>= 15 shifts + margin)
//  CNT_W     5   width of the WAIT down-counter (must hold WAIT_CYC)
// PORTS
//  clk         in   1   single clock, rising edge
//  reset       in   1   asynchronous, active-high
//  req0/req1   in   1   job request, level
//  info0/info1 in   16  INFO word: [15] direction, [14:0] amount (peripheral saturates >=16 to 15)
//  val0/val1   in   16  value to shift
//  done0/done1 out  1   one-cycle pulse, job of that port complete; rsp_data valid that cycle
//  rsp_data    out  16  shifted result of the last completed job, held until next RD_RES
//  busy        out  1   high in every state except IDLE
//  sh_reg_sel  out  2   peripheral register select
//  sh_wdata    out  16  to peripheral data_in
//  sh_cs       out  1   peripheral chip select
//  sh_we       out  1   peripheral write enable
//  sh_rdata    in   16  from peripheral data_out (combinational)
// BEHAVIOUR
//  Reset: state IDLE; done0/1, busy, sh_cs, sh_we = 0; sh_reg_sel = 2'b10; sh_wdata, rsp_data = 0;
//   rr pointer = port 1 last served (port 0 wins first tie). Reset mid-job aborts at once, no done.
//  FSM: IDLE -> WR_INFO -> WR_ORIG -> KICK -> WAIT -> RD_RES -> DONE -> IDLE.
//  IDLE: sh_cs=0. If any req, grant (rr), latch info/val of granted port, go WR_INFO next edge.
//   Both req: grant port not served last; pointer updated on grant.
//  WR_INFO: cs=1, we=1, reg_sel=00, wdata=latched info.  WR_ORIG: cs=1, we=1, reg_sel=01, wdata=val.
//  KICK: cs=1, we=0, reg_sel=11 for exactly one cycle (restarts shifter); counter loads WAIT_CYC-1.
//  WAIT: cs=1, we=0, reg_sel=10 (releases shifter reset; peripheral keeps its decode while cs low,
//   so cs must stay high here). Counter decrements; leave when it reaches 0 (WAIT_CYC cycles).
//  RD_RES: cs=1, we=0, reg_sel=10; rsp_data <= sh_rdata at the edge.
//  DONE: cs=0, done of granted port = 1 for this cycle; back to IDLE.
//  Latency: req seen in IDLE at cycle t -> done at t+5+WAIT_CYC (t+23 at default).
//  Operands latched at grant; changes after grant ignored. req dropped mid-job: job still
//   completes and done pulses. req still high in IDLE after done: treated as a new job.
//  Back-to-back with both requesting: strict alternation 0,1,0,1; one IDLE cycle between jobs.
//  sh_we only ever high in WR_INFO/WR_ORIG; never two states drive cs with we=1 and reg_sel=1x.
// CONFIGURATION
//  SHIFT_ARB_STATS_EN defined: adds outputs jobs0_cnt, jobs1_cnt (16 bits each), reset 0,
//   incremented on each done0/done1 pulse, wrap 16'hFFFF -> 0.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared package/include shift_arb_pkg: state encoding (7 states), register-select constants
//   REG_INFO=2'b00, REG_ORIG=2'b01, REG_RESULT=2'b10, REG_KICK=2'b11.
//  One sub-module: rr_arbiter2 (two requests, last-served pointer, grant one-hot, update on accept).
//  FSM, counter, operand latches and bus drive stay in shift_arbiter.
// TESTING (bench includes a peripheral model or the real shift peripheral)
//  1 req0, info0=16'h0003 (left 3), val0=16'h0001 -> bus: 00/0003, 01/0001, 11, 10xWAIT_CYC;
//    done0 at t+23, rsp_data=16'h0008, done1 never.
//  2 req0 and req1 same cycle after reset -> port 0 first, then port 1; done0 then done1 24 cycles apart.
//  3 info1=16'h8004 (right 4), val1=16'hF000 -> rsp_data=16'h0F00; info0=16'h0020 (amount 32) ->
//    shift by 15, rsp_data consistent with peripheral saturation.
//  4 req0 high, changes val0 and drops req0 after WR_ORIG -> job uses latched val0, done0 still pulses.
//  5 reset asserted during WAIT -> same cycle sh_cs=0, busy=0, no done; next req starts cleanly.
//  6 SHIFT_ARB_STATS_EN: 3 port-0 jobs, 2 port-1 jobs -> jobs0_cnt=3, jobs1_cnt=2; preload wrap check.

Source files
------------

// File: rtl/shift_arb_pkg.sv
// Shared definitions for shift_arbiter: FSM state encoding, peripheral
// register-select codes and default timing parameters.
package shift_arb_pkg;

    // One state per bus phase of a peripheral job.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_INFO = 3'd1,
        ST_WR_ORIG = 3'd2,
        ST_KICK    = 3'd3,
        ST_WAIT    = 3'd4,
        ST_RD_RES  = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    // Peripheral register map.
    localparam logic [1:0] REG_INFO   = 2'b00;
    localparam logic [1:0] REG_ORIG   = 2'b01;
    localparam logic [1:0] REG_RESULT = 2'b10;
    localparam logic [1:0] REG_KICK   = 2'b11;

    // Default WAIT length: 15 worst-case shifts plus margin.
    localparam int WAIT_CYC_DEF = 18;
    localparam int CNT_W_DEF    = 5;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter. Grant is combinational and one-hot;
// the last-served pointer moves only when the grant is accepted.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    // 0: port 0 served last, 1: port 1 served last.
    logic last_q;

    // Grant the lone requester, or on a tie the port not served last.
    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = last_q ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

    // Remember which port was granted; reset as if port 1 went last so port 0 wins the first tie.
    // NOTE: async reset in the sensitivity list, and sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (accept && (gnt != 2'b00)) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: shares the memory-mapped shift peripheral between two
// requesters. Each job runs WR_INFO, WR_ORIG, KICK, WAIT, RD_RES, DONE on
// the peripheral bus and returns the result with a one-cycle done pulse.
// Optional build macro SHIFT_ARB_STATS_EN adds per-port 16-bit job counters
// (jobs0_cnt/jobs1_cnt).
module shift_arbiter
    import shift_arb_pkg::*;
#(
    parameter int WAIT_CYC = WAIT_CYC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] info0,
    input  logic [15:0] info1,
    input  logic [15:0] val0,
    input  logic [15:0] val1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] rsp_data,
    output logic        busy,
    output logic [1:0]  sh_reg_sel,
    output logic [15:0] sh_wdata,
    output logic        sh_cs,
    output logic        sh_we,
    input  logic [15:0] sh_rdata
`ifdef SHIFT_ARB_STATS_EN
    ,
    output logic [15:0] jobs0_cnt,
    output logic [15:0] jobs1_cnt
`endif
);

    state_t             state_q;
    logic               port_q;     // granted port of the job in flight
    logic [15:0]        val_q;      // operand latched at grant
    logic [CNT_W-1:0]   cnt_q;      // WAIT down-counter
    logic               cs_q;
    logic               we_q;
    logic [1:0]         sel_q;
    logic [15:0]        wdata_q;
    logic [15:0]        rsp_q;
    logic               done0_q;
    logic               done1_q;
    logic               busy_q;

    logic [1:0]         gnt;
    logic               accept;

    assign accept = (state_q == ST_IDLE) && (req0 || req1);

    rr_arbiter2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    ({req1, req0}),
        .accept (accept),
        .gnt    (gnt)
    );

    // Job FSM: each arm picks the next state and registers the bus/handshake outputs for it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            port_q  <= 1'b0;
            val_q   <= '0;
            cnt_q   <= '0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= REG_RESULT;
            wdata_q <= '0;
            rsp_q   <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        port_q  <= gnt[1];
                        val_q   <= gnt[1] ? val1 : val0;
                        wdata_q <= gnt[1] ? info1 : info0;
                        cs_q    <= 1'b1;
                        we_q    <= 1'b1;
                        sel_q   <= REG_INFO;
                        busy_q  <= 1'b1;
                        state_q <= ST_WR_INFO;
                    end
                end
                ST_WR_INFO: begin
                    sel_q   <= REG_ORIG;
                    wdata_q <= val_q;
                    state_q <= ST_WR_ORIG;
                end
                ST_WR_ORIG: begin
                    we_q    <= 1'b0;
                    sel_q   <= REG_KICK;
                    cnt_q   <= CNT_W'(WAIT_CYC - 1);
                    state_q <= ST_KICK;
                end
                ST_KICK: begin
                    // cs stays high: the peripheral holds its last decode while deselected.
                    sel_q   <= REG_RESULT;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_RD_RES;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RD_RES: begin
                    rsp_q   <= sh_rdata;
                    cs_q    <= 1'b0;
                    done0_q <= ~port_q;
                    done1_q <= port_q;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    cs_q    <= 1'b0;
                    we_q    <= 1'b0;
                    sel_q   <= REG_RESULT;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign done0      = done0_q;
    assign done1      = done1_q;
    assign rsp_data   = rsp_q;
    assign busy       = busy_q;
    assign sh_reg_sel = sel_q;
    assign sh_wdata   = wdata_q;
    assign sh_cs      = cs_q;
    assign sh_we      = we_q;

`ifdef SHIFT_ARB_STATS_EN
    logic [15:0] jobs0_q;
    logic [15:0] jobs1_q;

    // Count completed jobs per port; bumps on the edge that raises the done pulse, wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jobs0_q <= '0;
            jobs1_q <= '0;
        end else if (state_q == ST_RD_RES) begin
            if (port_q) begin
                jobs1_q <= jobs1_q + 16'd1;
            end else begin
                jobs0_q <= jobs0_q + 16'd1;
            end
        end
    end

    assign jobs0_cnt = jobs0_q;
    assign jobs1_cnt = jobs1_q;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with a behavioural shift peripheral.
// Define SHIFT_ARB_STATS_EN to also exercise the job counters.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [15:0] info0, info1, val0, val1;
    logic        done0, done1, busy;
    logic [15:0] rsp_data;
    logic [1:0]  sh_reg_sel;
    logic [15:0] sh_wdata, sh_rdata;
    logic        sh_cs, sh_we;
`ifdef SHIFT_ARB_STATS_EN
    logic [15:0] jobs0_cnt, jobs1_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_viol   = 0;

    always #5 clk = ~clk;

    shift_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .info0      (info0),
        .info1      (info1),
        .val0       (val0),
        .val1       (val1),
        .done0      (done0),
        .done1      (done1),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .sh_reg_sel (sh_reg_sel),
        .sh_wdata   (sh_wdata),
        .sh_cs      (sh_cs),
        .sh_we      (sh_we),
        .sh_rdata   (sh_rdata)
`ifdef SHIFT_ARB_STATS_EN
        ,
        .jobs0_cnt  (jobs0_cnt),
        .jobs1_cnt  (jobs1_cnt)
`endif
    );

    // Behavioural shift peripheral: KICK loads ORIGINAL, then one shift per RESULT-selected cycle.
    logic [15:0] m_info, m_orig, m_acc;
    logic [4:0]  m_cnt;
    logic [4:0]  m_amt;
    assign m_amt    = (m_info[14:0] >= 15'd15) ? 5'd15 : {1'b0, m_info[3:0]};
    assign sh_rdata = m_acc;

    always @(posedge clk) begin
        if (sh_cs) begin
            case (sh_reg_sel)
                2'b00: if (sh_we) m_info <= sh_wdata;
                2'b01: if (sh_we) m_orig <= sh_wdata;
                2'b11: begin
                    m_acc <= m_orig;
                    m_cnt <= 5'd0;
                end
                default: if (m_cnt < m_amt) begin
                    m_acc <= m_info[15] ? (m_acc >> 1) : (m_acc << 1);
                    m_cnt <= m_cnt + 5'd1;
                end
            endcase
        end
    end

    // Protocol watch: a write strobe is only legal with cs high on INFO or ORIGINAL.
    always @(negedge clk) begin
        if (!reset && sh_we && !(sh_cs && !sh_reg_sel[1])) n_viol++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Wait up to budget negedges for done of `port`; lat = -1 if it never came.
    task automatic wait_done(input int port, input int budget, output int lat,
                             output logic [15:0] rsp, output bit other);
        lat = -1; rsp = '0; other = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if ((port == 0) ? done1 : done0) other = 1'b1;
            if ((port == 0) ? done0 : done1) begin
                lat = k;
                rsp = rsp_data;
                break;
            end
        end
    endtask

    // Single-port job with req dropped after the grant edge.
    task automatic run_job(input string tag, input int port, input logic [15:0] info,
                           input logic [15:0] val, input logic [15:0] exp);
        int lat; logic [15:0] rsp; bit other;
        if (port == 0) begin req0 = 1'b1; info0 = info; val0 = val; end
        else           begin req1 = 1'b1; info1 = info; val1 = val; end
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        wait_done(port, 30, lat, rsp, other);
        check({tag, "_lat"}, lat + 1, 23);
        check({tag, "_rsp"}, rsp, exp);
        check({tag, "_other"}, other, 0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat; logic [15:0] rsp; bit other;
        logic [19:0] bus [1:23];
        int reads, ndone;

        reset = 1'b1;
        req0 = 0; req1 = 0; info0 = 0; info1 = 0; val0 = 0; val1 = 0;
        repeat (3) @(negedge clk);
        check("rst_done", {done1, done0}, 0);
        check("rst_busy", busy, 0);
        check("rst_cs_we", {sh_cs, sh_we}, 0);
        check("rst_sel", sh_reg_sel, 2'b10);
        check("rst_wdata", sh_wdata, 0);
        check("rst_rsp", rsp_data, 0);
        reset = 1'b0;
        @(negedge clk);

        // 1: single port-0 job, full bus trace.
        req0 = 1'b1; info0 = 16'h0003; val0 = 16'h0001;
        ndone = 0;
        for (int k = 1; k <= 23; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req0 = 1'b0;
                check("t1_busy", busy, 1);
            end
            bus[k] = {sh_cs, sh_we, sh_reg_sel, sh_wdata};
            if (done0 || done1) ndone++;
        end
        check("t1_info", bus[1], 20'hC0003);
        check("t1_orig", bus[2], 20'hD0001);
        check("t1_kick", bus[3][19:16], 4'hB);
        reads = 0;
        for (int k = 4; k <= 22; k++) if (bus[k][19:16] == 4'hA) reads++;
        check("t1_wait_cycles", reads, 19);
        check("t1_done_cyc", {bus[23][19], done0, done1}, 3'b010);
        check("t1_early_done", ndone, 1);
        check("t1_rsp", rsp_data, 16'h0008);
        @(negedge clk);
        check("t1_idle_busy", busy, 0);
        ndone = 0;
        repeat (30) begin @(negedge clk); if (done0 || done1) ndone++; end
        check("t1_no_more_done", ndone, 0);

        // 2: simultaneous requests alternate 0,1,0.
        reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
        info0 = 16'h0001; val0 = 16'h0101; info1 = 16'h8001; val1 = 16'h0100;
        req0 = 1'b1; req1 = 1'b1;
        wait_done(0, 30, lat, rsp, other);
        check("t2_lat0", lat, 23);
        check("t2_rsp0", rsp, 16'h0202);
        wait_done(1, 30, lat, rsp, other);
        check("t2_lat1", lat, 24);
        check("t2_rsp1", rsp, 16'h0080);
        check("t2_only1", other, 0);
        wait_done(0, 30, lat, rsp, other);
        req0 = 1'b0; req1 = 1'b0;
        check("t2_lat0b", lat, 24);
        check("t2_only0b", other, 0);
        repeat (2) @(negedge clk);

        // 3: right shift and saturated amount.
        run_job("t3_right4", 1, 16'h8004, 16'hF000, 16'h0F00);
        run_job("t3_sat32", 0, 16'h0020, 16'h0003, 16'h8000);

        // 4: operands latched at grant; req dropped mid-job.
        req0 = 1'b1; info0 = 16'h0002; val0 = 16'h0005;
        @(negedge clk);
        req0 = 1'b0; val0 = 16'hFFFF; info0 = 16'h000F;
        @(negedge clk);
        check("t4_orig_latched", sh_wdata, 16'h0005);
        wait_done(0, 30, lat, rsp, other);
        check("t4_lat", lat + 2, 23);
        check("t4_rsp", rsp, 16'h0014);
        @(negedge clk);

        // 5: reset during WAIT aborts immediately.
        req0 = 1'b1; info0 = 16'h0001; val0 = 16'h0001;
        @(negedge clk);
        req0 = 1'b0;
        repeat (9) @(negedge clk);
        check("t5_in_wait", {sh_cs, sh_reg_sel}, 3'b110);
        reset = 1'b1;
        #1;
        check("t5_abort", {sh_cs, busy, done0, done1}, 0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (30) begin @(negedge clk); if (done0 || done1) ndone++; end
        check("t5_no_done", ndone, 0);
        run_job("t5_restart", 1, 16'h0004, 16'h0001, 16'h0010);

`ifdef SHIFT_ARB_STATS_EN
        // 6: job counters and wrap.
        reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
        check("t6_rst_cnt", {jobs0_cnt, jobs1_cnt}, 0);
        run_job("t6_a", 0, 16'h0001, 16'h0001, 16'h0002);
        run_job("t6_b", 1, 16'h0001, 16'h0001, 16'h0002);
        run_job("t6_c", 0, 16'h0001, 16'h0001, 16'h0002);
        run_job("t6_d", 1, 16'h0001, 16'h0001, 16'h0002);
        run_job("t6_e", 0, 16'h0001, 16'h0001, 16'h0002);
        check("t6_jobs0", jobs0_cnt, 3);
        check("t6_jobs1", jobs1_cnt, 2);
        force dut.jobs0_q = 16'hFFFF;
        #1;
        release dut.jobs0_q;
        @(negedge clk);
        check("t6_preload", jobs0_cnt, 16'hFFFF);
        run_job("t6_wrap", 0, 16'h0000, 16'h1234, 16'h1234);
        check("t6_wrapped", jobs0_cnt, 0);
        check("t6_jobs1_hold", jobs1_cnt, 2);
`endif

        check("protocol_we", n_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
